// File: rtl/uart_frame_chck.sv
// UART receive frame checker: walks one sampled bit per bit period through
// start, data, optional parity and stop bits, and flags glitch/parity/framing errors.
module uart_frame_chck #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_chk_en,
    input  logic                  i_frm_start,
    input  logic                  i_bit_vld,
    input  logic                  i_sampled_bit,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic                  i_cnt_clr,
    output logic                  o_strt_glitch,
    output logic                  o_frm_done,
    output logic [DATA_WIDTH-1:0] o_frm_data,
    output logic                  o_par_err,
    output logic                  o_stop_err,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_glitch_cnt,
    output logic [CNT_WIDTH-1:0]  o_par_cnt,
    output logic [CNT_WIDTH-1:0]  o_stop_cnt
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_DATA_IDX = BCW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP_IDX = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  r_stop_idx;
    logic                  r_par_acc;
    logic                  r_par_mis;
    logic                  r_stop_acc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_glitch;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_frm_data;
    logic                  r_par_err;
    logic                  r_stop_err;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_glitch_cnt;
    logic [CNT_WIDTH-1:0]  r_par_cnt;
    logic [CNT_WIDTH-1:0]  r_stop_cnt;

    logic w_glitch_evt;
    logic w_done_evt;
    logic w_par_err_fin;
    logic w_stop_err_fin;

    // Parity bit the transmitter should have sent for the accumulated data XOR.
    function automatic logic exp_parity(input logic par_acc, input logic odd);
        return par_acc ^ odd;
    endfunction

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + CNT_WIDTH'(1);
        end
        return res;
    endfunction

    // Frame-level events decided by the current bit strobe.
    always_comb begin
        w_glitch_evt   = 1'b0;
        w_done_evt     = 1'b0;
        w_par_err_fin  = r_par_en & r_par_mis;
        w_stop_err_fin = r_stop_acc | ~i_sampled_bit;
        if (i_chk_en && i_bit_vld) begin
            w_glitch_evt = (r_state == S_START) && i_sampled_bit;
            w_done_evt   = (r_state == S_STOP) && (r_stop_idx == LAST_STOP_IDX);
        end else begin
            w_glitch_evt = 1'b0;
            w_done_evt   = 1'b0;
        end
    end

    // Frame FSM with registered status outputs and statistics counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_idx   <= 1'b0;
            r_par_acc    <= 1'b0;
            r_par_mis    <= 1'b0;
            r_stop_acc   <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_glitch     <= 1'b0;
            r_done       <= 1'b0;
            r_frm_data   <= '0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_glitch_cnt <= '0;
            r_par_cnt    <= '0;
            r_stop_cnt   <= '0;
        end else begin
            r_glitch <= 1'b0;
            r_done   <= 1'b0;
            if (!i_chk_en) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_frm_start) begin
                            r_par_en  <= i_par_en;
                            r_par_typ <= i_par_typ;
                            r_state   <= S_START;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (i_bit_vld) begin
                            if (i_sampled_bit) begin
                                r_glitch <= 1'b1;
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                            end else begin
                                r_bit_cnt  <= '0;
                                r_stop_idx <= 1'b0;
                                r_par_acc  <= 1'b0;
                                r_par_mis  <= 1'b0;
                                r_stop_acc <= 1'b0;
                                r_state    <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (i_bit_vld) begin
                            // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom.
                            r_shift   <= {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                            r_par_acc <= r_par_acc ^ i_sampled_bit;
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            if (r_bit_cnt == LAST_DATA_IDX) begin
                                r_state <= r_par_en ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (i_bit_vld) begin
                            r_par_mis <= (i_sampled_bit != exp_parity(r_par_acc, r_par_typ));
                            r_state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (i_bit_vld) begin
                            if (w_done_evt) begin
                                r_done     <= 1'b1;
                                r_frm_data <= r_shift;
                                r_par_err  <= w_par_err_fin;
                                r_stop_err <= w_stop_err_fin;
                                r_state    <= S_IDLE;
                                r_busy     <= 1'b0;
                            end else begin
                                r_stop_acc <= w_stop_err_fin;
                                r_stop_idx <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // A clear in the same cycle as an error wins over the increment.
            if (i_cnt_clr) begin
                r_glitch_cnt <= '0;
                r_par_cnt    <= '0;
                r_stop_cnt   <= '0;
            end else begin
                if (w_glitch_evt) begin
                    r_glitch_cnt <= sat_inc(r_glitch_cnt);
                end
                if (w_done_evt && w_par_err_fin) begin
                    r_par_cnt <= sat_inc(r_par_cnt);
                end
                if (w_done_evt && w_stop_err_fin) begin
                    r_stop_cnt <= sat_inc(r_stop_cnt);
                end
            end
        end
    end

    assign o_strt_glitch = r_glitch;
    assign o_frm_done    = r_done;
    assign o_frm_data    = r_frm_data;
    assign o_par_err     = r_par_err;
    assign o_stop_err    = r_stop_err;
    assign o_busy        = r_busy;
    assign o_glitch_cnt  = r_glitch_cnt;
    assign o_par_cnt     = r_par_cnt;
    assign o_stop_cnt    = r_stop_cnt;

endmodule

// File: tb/tb_uart_frame_chck.sv
// Bench for uart_frame_chck: three configurations share one stimulus stream and are
// checked every cycle against a frame-level model built from the collected bit list.
module tb_uart_frame_chck;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b1;
    logic frm_start = 1'b0;
    logic bit_vld = 1'b0;
    logic sampled_bit = 1'b1;
    logic par_en = 1'b0;
    logic par_typ = 1'b0;
    logic cnt_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    logic       d_glitch [3];
    logic       d_done   [3];
    logic [7:0] d_data   [3];
    logic       d_perr   [3];
    logic       d_serr   [3];
    logic       d_busy   [3];
    logic [7:0] gc0, pc0, sc0, gc1, pc1, sc1;
    logic [1:0] gc2, pc2, sc2;
    int         d_gcnt [3];
    int         d_pcnt [3];
    int         d_scnt [3];

    always_comb begin
        d_gcnt[0] = int'(gc0); d_pcnt[0] = int'(pc0); d_scnt[0] = int'(sc0);
        d_gcnt[1] = int'(gc1); d_pcnt[1] = int'(pc1); d_scnt[1] = int'(sc1);
        d_gcnt[2] = int'(gc2); d_pcnt[2] = int'(pc2); d_scnt[2] = int'(sc2);
    end

    uart_frame_chck #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_chk_en(chk_en), .i_frm_start(frm_start),
        .i_bit_vld(bit_vld), .i_sampled_bit(sampled_bit), .i_par_en(par_en),
        .i_par_typ(par_typ), .i_cnt_clr(cnt_clr), .o_strt_glitch(d_glitch[0]),
        .o_frm_done(d_done[0]), .o_frm_data(d_data[0]), .o_par_err(d_perr[0]),
        .o_stop_err(d_serr[0]), .o_busy(d_busy[0]), .o_glitch_cnt(gc0),
        .o_par_cnt(pc0), .o_stop_cnt(sc0));

    uart_frame_chck #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_chk_en(chk_en), .i_frm_start(frm_start),
        .i_bit_vld(bit_vld), .i_sampled_bit(sampled_bit), .i_par_en(par_en),
        .i_par_typ(par_typ), .i_cnt_clr(cnt_clr), .o_strt_glitch(d_glitch[1]),
        .o_frm_done(d_done[1]), .o_frm_data(d_data[1]), .o_par_err(d_perr[1]),
        .o_stop_err(d_serr[1]), .o_busy(d_busy[1]), .o_glitch_cnt(gc1),
        .o_par_cnt(pc1), .o_stop_cnt(sc1));

    uart_frame_chck #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_chk_en(chk_en), .i_frm_start(frm_start),
        .i_bit_vld(bit_vld), .i_sampled_bit(sampled_bit), .i_par_en(par_en),
        .i_par_typ(par_typ), .i_cnt_clr(cnt_clr), .o_strt_glitch(d_glitch[2]),
        .o_frm_done(d_done[2]), .o_frm_data(d_data[2]), .o_par_err(d_perr[2]),
        .o_stop_err(d_serr[2]), .o_busy(d_busy[2]), .o_glitch_cnt(gc2),
        .o_par_cnt(pc2), .o_stop_cnt(sc2));

    function automatic int stop_bits_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int cnt_max_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    // Model state: a frame is just the list of bits collected since an accepted start.
    bit        m_act  [3];
    int        m_n    [3];
    bit [15:0] m_bits [3];
    bit        m_pe   [3];
    bit        m_pt   [3];
    bit        m_glitch [3];
    bit        m_done [3];
    bit [7:0]  m_data [3];
    bit        m_perr [3];
    bit        m_serr [3];
    int        m_gcnt [3];
    int        m_pcnt [3];
    int        m_scnt [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit gi, pi, si;
            int flen;
            bit [7:0] w;
            gi = 1'b0; pi = 1'b0; si = 1'b0;
            if (rst) begin
                m_act[i] = 1'b0; m_n[i] = 0; m_bits[i] = '0; m_pe[i] = 1'b0; m_pt[i] = 1'b0;
                m_glitch[i] = 1'b0; m_done[i] = 1'b0; m_data[i] = '0;
                m_perr[i] = 1'b0; m_serr[i] = 1'b0;
                m_gcnt[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
            end else begin
                m_glitch[i] = 1'b0;
                m_done[i] = 1'b0;
                if (!chk_en) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i]) begin
                    if (frm_start) begin
                        m_act[i] = 1'b1; m_n[i] = 0; m_bits[i] = '0;
                        m_pe[i] = par_en; m_pt[i] = par_typ;
                    end
                end else if (bit_vld) begin
                    m_bits[i][m_n[i]] = sampled_bit;
                    m_n[i] = m_n[i] + 1;
                    flen = 1 + 8 + int'(m_pe[i]) + stop_bits_of(i);
                    if (m_n[i] == 1 && m_bits[i][0]) begin
                        m_glitch[i] = 1'b1; m_act[i] = 1'b0; gi = 1'b1;
                    end else if (m_n[i] == flen) begin
                        w = m_bits[i][8:1];
                        m_act[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_data[i] = w;
                        m_perr[i] = m_pe[i] && (m_bits[i][9] != (bit'($countones(w) % 2) ^ m_pt[i]));
                        m_serr[i] = 1'b0;
                        for (int k = 0; k < stop_bits_of(i); k++)
                            if (!m_bits[i][9 + int'(m_pe[i]) + k]) m_serr[i] = 1'b1;
                        pi = m_perr[i];
                        si = m_serr[i];
                    end
                end
                if (cnt_clr) begin
                    m_gcnt[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
                end else begin
                    if (gi && m_gcnt[i] < cnt_max_of(i)) m_gcnt[i] = m_gcnt[i] + 1;
                    if (pi && m_pcnt[i] < cnt_max_of(i)) m_pcnt[i] = m_pcnt[i] + 1;
                    if (si && m_scnt[i] < cnt_max_of(i)) m_scnt[i] = m_scnt[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s[u%0d] got=%0h expected=%0h at %0t", name, idx, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                chk("strt_glitch", i, int'(d_glitch[i]), int'(m_glitch[i]));
                chk("frm_done", i, int'(d_done[i]), int'(m_done[i]));
                chk("frm_data", i, int'(d_data[i]), int'(m_data[i]));
                chk("par_err", i, int'(d_perr[i]), int'(m_perr[i]));
                chk("stop_err", i, int'(d_serr[i]), int'(m_serr[i]));
                chk("busy", i, int'(d_busy[i]), int'(m_act[i]));
                chk("glitch_cnt", i, d_gcnt[i], m_gcnt[i]);
                chk("par_cnt", i, d_pcnt[i], m_pcnt[i]);
                chk("stop_cnt", i, d_scnt[i], m_scnt[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic v);
        tick();
        bit_vld = 1'b1;
        sampled_bit = v;
        tick();
        bit_vld = 1'b0;
    endtask

    task automatic begin_frame(input logic pe, input logic pt, input logic junk_vld);
        tick();
        frm_start = 1'b1; par_en = pe; par_typ = pt;
        bit_vld = junk_vld; sampled_bit = 1'b1;
        tick();
        frm_start = 1'b0; bit_vld = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
    endtask

    task automatic flush();
        tick();
        chk_en = 1'b0;
        tick();
        chk_en = 1'b1;
    endtask

    task automatic glitch_frame();
        begin_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
    endtask

    initial begin
        @(posedge clk);
        #2;
        cmp_on = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_busy", 0, int'(d_busy[0]), 0);

        // Even parity 0xA5, a stray strobe alongside frm_start must be ignored.
        begin_frame(1'b1, 1'b0, 1'b1);
        send_bit(1'b0); send_data(8'hA5); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        chk("lit_a5_done", 0, int'(d_done[0]), 1);
        chk("lit_a5_data", 0, int'(d_data[0]), 8'hA5);
        chk("lit_a5_perr", 0, int'(d_perr[0]), 0);
        flush();

        // Start glitch, then a clean 0x3C.
        glitch_frame();
        @(negedge clk);
        chk("lit_glitch_pulse", 0, int'(d_glitch[0]), 1);
        chk("lit_glitch_cnt", 0, d_gcnt[0], 1);
        chk("lit_glitch_busy", 0, int'(d_busy[0]), 0);
        begin_frame(1'b1, 1'b0, 1'b0);
        send_bit(1'b0); send_data(8'h3C); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        chk("lit_3c_data", 0, int'(d_data[0]), 8'h3C);
        flush();

        // Odd parity on 0x0F expects 1; sending 0 is an error.
        begin_frame(1'b1, 1'b1, 1'b0);
        send_bit(1'b0); send_data(8'h0F); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        chk("lit_0f_perr", 0, int'(d_perr[0]), 1);
        chk("lit_0f_pcnt", 0, d_pcnt[0], 1);
        chk("lit_0f_serr", 0, int'(d_serr[0]), 0);
        flush();

        // Two stop bits on u1, second one bad.
        begin_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b0); send_data(8'h55); send_bit(1'b1);
        @(negedge clk);
        chk("lit_55_early_done", 1, int'(d_done[1]), 0);
        send_bit(1'b0);
        @(negedge clk);
        chk("lit_55_done", 1, int'(d_done[1]), 1);
        chk("lit_55_serr", 1, int'(d_serr[1]), 1);
        chk("lit_55_scnt", 1, d_scnt[1], 1);
        flush();

        // Saturation on the 2-bit counters, then clear racing a glitch.
        for (int g = 0; g < 5; g++) glitch_frame();
        @(negedge clk);
        chk("lit_sat_gcnt", 2, d_gcnt[2], 3);
        begin_frame(1'b0, 1'b0, 1'b0);
        tick();
        bit_vld = 1'b1; sampled_bit = 1'b1; cnt_clr = 1'b1;
        tick();
        bit_vld = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        chk("lit_clr_pulse", 2, int'(d_glitch[2]), 1);
        chk("lit_clr_gcnt", 2, d_gcnt[2], 0);

        // Reset partway through the data bits, then 0xFF with even parity.
        begin_frame(1'b1, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_busy", 0, int'(d_busy[0]), 0);
        chk("lit_rst_data", 0, int'(d_data[0]), 0);
        begin_frame(1'b1, 1'b0, 1'b0);
        send_bit(1'b0); send_data(8'hFF); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        chk("lit_ff_data", 0, int'(d_data[0]), 8'hFF);
        chk("lit_ff_perr", 0, int'(d_perr[0]), 0);
        send_bit(1'b1);
        @(negedge clk);
        chk("lit_ff_u1_serr", 1, int'(d_serr[1]), 0);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_chck.md
Name: uart_frame_chck

Overview:
Parametrised UART receive frame checker, successor to the single start-bit glitch check. It consumes one sampled bit per bit period from the oversampling/sampler stage and tracks the frame through start, data, optional parity and stop bits. It reports start glitch, parity error and stop (framing) error, and delivers the received data word. Saturating per-error statistics counters are exposed for status registers.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9), received LSB-first
STOP_BITS, 1, number of stop bits checked (legal 1 or 2)
CNT_WIDTH, 8, width of each saturating error counter (legal 1..16)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
chk_en  input  1  checker enable; 0 forces IDLE at next edge
frm_start  input  1  start-edge detected, begin frame (accepted only in IDLE)
bit_vld  input  1  one-cycle strobe: sampled_bit is valid for the current bit period
sampled_bit  input  1  majority-sampled line value
par_en  input  1  parity bit present (latched at frm_start)
par_typ  input  1  0 = even, 1 = odd (latched at frm_start)
cnt_clr  input  1  synchronous clear of all error counters
strt_glitch  output  1  one-cycle pulse: start sample was 1
frm_done  output  1  one-cycle pulse: complete frame checked
frm_data  output  DATA_WIDTH  received word, updated with frm_done
par_err  output  1  parity mismatch for last completed frame
stop_err  output  1  any stop bit sampled 0 in last completed frame
busy  output  1  FSM not in IDLE
glitch_cnt  output  CNT_WIDTH  start glitches, saturating
par_cnt  output  CNT_WIDTH  frames with par_err, saturating
stop_cnt  output  CNT_WIDTH  frames with stop_err, saturating

Behaviour:
- Reset (rst=1 at clk edge): FSM to IDLE; all outputs, shift register, bit counter, latched config and counters set to 0. Reset mid-frame discards the frame with no pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on frm_start=1 with chk_en=1, latch par_en/par_typ and go to START. A bit_vld in the same cycle is ignored. frm_start is ignored outside IDLE.
- START: on bit_vld:
  - sampled_bit=1: strt_glitch=1 the next cycle, glitch_cnt increments, go to IDLE, no frm_done.
  - sampled_bit=0: clear the bit counter and running parity, go to DATA.
- DATA: on each bit_vld, shift sampled_bit into the MSB of the shift register (LSB-first reception) and XOR it into the running parity. After the DATA_WIDTH-th sample, go to PARITY if latched par_en=1, else go to STOP.
- PARITY: expected bit = running XOR for even, or its inverse for odd. On bit_vld, record mismatch internally and go to STOP.
- STOP: on each bit_vld, a sample of 0 sets the internal stop-error flag. On the STOP_BITS-th sample, go to IDLE. In the following cycle:
  - frm_done=1 for exactly one cycle.
  - frm_data, par_err and stop_err are loaded.
  - par_cnt and/or stop_cnt increment (at most once each per frame).
- frm_data, par_err and stop_err hold until the next frm_done or reset. par_err=0 whenever parity is disabled.
- Latency: strt_glitch and frm_done assert 1 cycle after the deciding bit_vld edge.
- Cycles without bit_vld: no state change.
- chk_en=0: FSM goes to IDLE at the next edge. Any frame in progress is dropped with no pulses and no counting. Counters and held outputs are retained.
- Counters: increment by 1, hold at 2^CNT_WIDTH-1. cnt_clr=1 sets all counters to 0; if cnt_clr coincides with an increment, the result is 0 (clear wins).
- busy=1 in START, DATA, PARITY and STOP.
- A new frm_start is accepted in the same cycle frm_done or strt_glitch is asserted, because the FSM is already in IDLE.

Test Plan:
- DATA_WIDTH=8, STOP_BITS=1, par_en=1, par_typ=0. Send start 0; data 0xA5 LSB-first (1,0,1,0,0,1,0,1); parity 0; stop 1. Required: frm_done pulse 1 cycle after stop bit_vld, frm_data=0xA5, par_err=0, stop_err=0, all counters 0.
- Start sample=1. Required: strt_glitch single pulse, glitch_cnt=1, no frm_done, busy=0. A following clean frame of 0x3C is received correctly.
- par_typ=1, data 0x0F (expected parity 1), send parity 0. Required: par_err=1, par_cnt=1, stop_err=0, frm_data=0x0F.
- STOP_BITS=2, par_en=0, data 0x55, stops 1 then 0. Required: stop_err=1, stop_cnt=1. frm_done is not asserted after the first stop sample, only after the second.
- CNT_WIDTH=2: five consecutive glitches give glitch_cnt=3 (saturated). Then cnt_clr together with a sixth glitch gives glitch_cnt=0 while strt_glitch still pulses.
- rst=1 after 4 data bits of a frame. Required: all outputs 0, busy=0, no frm_done. The next frame 0xFF with even parity 0 passes with no errors.
